dmem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port data RAM used by the MIPS MEM stage. Shares the RAM between the pipeline (load/store traffic) and the debug unit (memory dump/program load). Issues at most one access per cycle, stalls the pipeline when it loses arbitration, and returns read data with the RAM's one-cycle latency. Sits between the MEM stage and the `rammemory` instance, replacing the direct MEM-stage-to-RAM connection.

---
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter between the MEM-stage pipeline port and the debug unit.
// One access per cycle; a starve counter and a lock mode give debug guaranteed progress.
module dmem_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_locked,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {NORMAL, STARVED, LOCK} state_t;

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  state_t     state;
  logic [2:0] scnt;
  logic [2:0] scnt_inc;
  logic       p_gnt;
  req_t       p_bus, d_bus, m_bus;

  assign p_bus = '{we: p_we, addr: p_addr, wdata: p_wdata};
  assign d_bus = '{we: d_we, addr: d_addr, wdata: d_wdata};

  always_comb begin
    p_gnt = 1'b0;
    d_gnt = 1'b0;
    case (state)
      NORMAL: begin
        p_gnt = p_req;
        d_gnt = d_req & ~p_req;
      end
      STARVED: begin
        d_gnt = d_req;
        p_gnt = p_req & ~d_req;
      end
      LOCK: begin
        d_gnt = d_req;
      end
      default: begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
      end
    endcase
  end

  assign p_stall  = p_req & ~p_gnt;
  // Idle cycles park the RAM port on the pipeline bundle with the write disabled.
  assign m_bus    = d_gnt ? d_bus : p_bus;
  assign mem_addr = m_bus.addr;
  assign mem_din  = m_bus.wdata;
  assign mem_we   = (p_gnt & p_we) | (d_gnt & d_we);

  assign p_rdata  = p_rvalid ? mem_dout : '0;
  assign d_rdata  = d_rvalid ? mem_dout : '0;
  assign scnt_inc = (scnt >= SMAX) ? SMAX : scnt + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= NORMAL;
      scnt     <= '0;
      p_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      d_locked <= 1'b0;
    end else begin
      p_rvalid <= p_gnt & ~p_we;
      d_rvalid <= d_gnt & ~d_we;
      if (d_lock) begin
        state    <= LOCK;
        scnt     <= '0;
        d_locked <= 1'b1;
      end else begin
        d_locked <= 1'b0;
        if (state == LOCK) begin
          state <= NORMAL;
          scnt  <= '0;
        end else begin
          scnt <= (d_req & ~d_gnt) ? scnt_inc : 3'd0;
          case (state)
            NORMAL:
              if (d_req && !d_gnt && scnt_inc == SMAX) state <= STARVED;
            // Debug always wins here, so one cycle either grants it or sees it withdraw.
            STARVED: state <= NORMAL;
            default: state <= NORMAL;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM and read-data scoreboards.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_req, p_we;
  logic [12:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_stall, p_rvalid;
  logic [31:0] p_rdata;
  logic        d_req, d_we, d_lock;
  logic [12:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid, d_locked;
  logic [31:0] d_rdata;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_din, mem_dout;

  logic [31:0] ram [0:8191];
  logic [31:0] pq[$];
  logic [31:0] dq[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(13), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_locked(d_locked),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Read returns are popped one cycle after the grant the bench expected.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (p_rvalid) begin
        chk1("p_rvalid_expected", pq.size() != 0, 1'b1);
        if (pq.size() != 0) chk32("p_rdata", p_rdata, pq.pop_front());
      end
      if (d_rvalid) begin
        chk1("d_rvalid_expected", dq.size() != 0, 1'b1);
        if (dq.size() != 0) chk32("d_rdata", d_rdata, dq.pop_front());
      end
    end
  end

  task automatic drive(input logic pr, input logic pw, input logic [12:0] pa, input logic [31:0] pd,
                       input logic dr, input logic dw, input logic [12:0] da, input logic [31:0] dd,
                       input logic dl);
    @(negedge clk);
    p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_lock = dl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 13'h0, 32'h0, 0, 0, 13'h0, 32'h0, 0);
  endtask

  initial begin
    reset = 1'b0;
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_lock = 0;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_p_rvalid", p_rvalid, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);
    chk1("rst_d_locked", d_locked, 1'b0);
    chk1("rst_d_gnt", d_gnt, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);

    // Reset asserted while a read and a lock are in flight.
    @(negedge clk); reset = 1'b1;
    drive(1, 0, 13'h010, 32'h0, 0, 0, 13'h0, 32'h0, 1);
    chk1("rr_p_stall", p_stall, 1'b0);
    @(posedge clk); #1;
    chk1("rr_locked_pre", d_locked, 1'b1);
    reset = 1'b0;
    p_req = 0; d_lock = 0;
    #1;
    chk1("rr_p_rvalid", p_rvalid, 1'b0);
    chk1("rr_d_locked", d_locked, 1'b0);
    @(negedge clk); reset = 1'b1;
    idle();
    chk1("rr_idle_stall", p_stall, 1'b0);
    chk1("rr_idle_gnt", d_gnt, 1'b0);

    // Pipeline-only store then load.
    drive(1, 1, 13'h010, 32'hDEADBEEF, 0, 0, 13'h0, 32'h0, 0);
    chk1("ps_stall", p_stall, 1'b0);
    chk1("ps_mem_we", mem_we, 1'b1);
    chk32("ps_mem_addr", 32'(mem_addr), 32'h010);
    chk32("ps_mem_din", mem_din, 32'hDEADBEEF);
    drive(1, 0, 13'h010, 32'h0, 0, 0, 13'h0, 32'h0, 0);
    pq.push_back(32'hDEADBEEF);
    chk1("pl_stall", p_stall, 1'b0);
    chk1("pl_mem_we", mem_we, 1'b0);
    chk1("ps_no_rvalid", p_rvalid, 1'b0);
    idle();
    chk1("pl_rvalid", p_rvalid, 1'b1);

    // Conflict: debug starves for four cycles, then wins once.
    drive(0, 0, 13'h0, 32'h0, 1, 1, 13'h020, 32'hCAFEF00D, 0);
    chk1("dw_gnt", d_gnt, 1'b1);
    chk1("dw_mem_we", mem_we, 1'b1);
    idle();
    for (int k = 1; k <= 7; k++) begin
      drive(1, 0, 13'h010, 32'h0, 1, 0, 13'h020, 32'h0, 0);
      if (k == 5) dq.push_back(32'hCAFEF00D);
      else        pq.push_back(32'hDEADBEEF);
      chk1($sformatf("cf_d_gnt_%0d", k), d_gnt, k == 5);
      chk1($sformatf("cf_p_stall_%0d", k), p_stall, k == 5);
      chk32($sformatf("cf_addr_%0d", k), 32'(mem_addr), (k == 5) ? 32'h020 : 32'h010);
      chk1($sformatf("cf_d_rvalid_%0d", k), d_rvalid, k == 6);
    end
    idle();

    // Debug withdraws while starved; counter must restart from zero.
    for (int k = 1; k <= 11; k++) begin
      if (k == 5 || k == 11) drive(1, 1, 13'h050, 32'hAAAA0000, 0, 0, 13'h0, 32'h0, 0);
      else                   drive(1, 1, 13'h050, 32'hAAAA0000, 1, 1, 13'h050, 32'hBBBB0000, 0);
      chk1($sformatf("er_d_gnt_%0d", k), d_gnt, k == 10);
      chk1($sformatf("er_p_stall_%0d", k), p_stall, k == 10);
      if (k == 10) chk32("er_debug_wins_din", mem_din, 32'hBBBB0000);
      if (k == 11) chk32("er_pipe_later_din", mem_din, 32'hAAAA0000);
    end
    drive(1, 0, 13'h050, 32'h0, 0, 0, 13'h0, 32'h0, 0);
    pq.push_back(32'hAAAA0000);

    // Lock: pipeline held off, debug writes a block.
    drive(1, 0, 13'h010, 32'h0, 0, 0, 13'h0, 32'h0, 1);
    pq.push_back(32'hDEADBEEF);
    chk1("lk_entry_stall", p_stall, 1'b0);
    chk1("lk_entry_locked", d_locked, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 13'h010, 32'h0, 1, 1, 13'(i), 32'(i + 1), 1);
      chk1($sformatf("lk_locked_%0d", i), d_locked, 1'b1);
      chk1($sformatf("lk_stall_%0d", i), p_stall, 1'b1);
      chk1($sformatf("lk_gnt_%0d", i), d_gnt, 1'b1);
      chk32($sformatf("lk_addr_%0d", i), 32'(mem_addr), 32'(i));
      chk32($sformatf("lk_din_%0d", i), mem_din, 32'(i + 1));
    end
    drive(1, 0, 13'h010, 32'h0, 0, 0, 13'h0, 32'h0, 0);
    chk1("lk_exit_stall", p_stall, 1'b1);
    chk1("lk_exit_locked", d_locked, 1'b1);
    drive(1, 0, 13'h010, 32'h0, 0, 0, 13'h0, 32'h0, 0);
    pq.push_back(32'hDEADBEEF);
    chk1("lk_after_stall", p_stall, 1'b0);
    chk1("lk_after_locked", d_locked, 1'b0);
    drive(0, 0, 13'h0, 32'h0, 1, 0, 13'h003, 32'h0, 0);
    dq.push_back(32'h00000004);
    chk1("lk_rd3_gnt", d_gnt, 1'b1);
    drive(0, 0, 13'h0, 32'h0, 1, 0, 13'h007, 32'h0, 0);
    dq.push_back(32'h00000008);
    idle();

    // Idle: nothing issued, nothing returned.
    idle();
    for (int i = 0; i < 20; i++) begin
      idle();
      chk1($sformatf("id_mem_we_%0d", i), mem_we, 1'b0);
      chk1($sformatf("id_p_rvalid_%0d", i), p_rvalid, 1'b0);
      chk1($sformatf("id_d_rvalid_%0d", i), d_rvalid, 1'b0);
    end

    chk32("pq_drained", 32'(pq.size()), 32'd0);
    chk32("dq_drained", 32'(dq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
